// File: rtl/tensor_mem_responder.sv
// tensor_mem_responder: DEPTH x DW register memory serving independent burst read and write engines.
// Defining TENSOR_MEM_BOUNDS_CHECK_EN flags requests that run past DEPTH-1 instead of wrapping.
module tensor_mem_responder #(
  parameter int DEPTH = 2048,
  parameter int BEATS = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] ar_addr,
  input  logic          ar_valid,
  output logic          ar_ready,
  output logic [DW-1:0] r_data,
  output logic          r_last,
  output logic          r_valid,
  input  logic          r_ready,
  input  logic [AW-1:0] aw_addr,
  input  logic          aw_valid,
  output logic          aw_ready,
  input  logic [DW-1:0] w_data,
  input  logic          w_last,
  input  logic          w_valid,
  output logic          w_ready,
  output logic          b_resp,
  output logic          b_valid,
  input  logic          b_ready
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  logic [DW-1:0] r_mem [DEPTH];
  rd_state_t r_rstate, w_rstate_nx;
  wr_state_t r_wstate, w_wstate_nx;
  logic [IW-1:0] r_rbase, r_waddr, w_ar_idx, w_aw_idx, w_ridx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [DW-1:0] r_rdata;
  logic r_rlast;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_rload, w_rzero, w_werr;
  assign ar_ready = reset_n && r_rstate == RD_IDLE;
  assign r_valid  = reset_n && r_rstate == RD_BURST;
  assign r_last   = reset_n && r_rlast;
  assign r_data   = reset_n ? r_rdata : '0;
  assign aw_ready = reset_n && r_wstate == WR_IDLE;
  assign w_ready  = reset_n && r_wstate == WR_DATA;
  assign b_valid  = reset_n && r_wstate == WR_RESP;
  assign w_ar_hs = ar_valid && ar_ready;
  assign w_r_hs  = r_valid && r_ready;
  assign w_aw_hs = aw_valid && aw_ready;
  assign w_w_hs  = w_valid && w_ready;
  assign w_b_hs  = b_valid && b_ready;
  // Modulo on the zero-extended address keeps the full request address in play for wrap.
  assign w_ar_idx = IW'({1'b0, ar_addr} % (AW+1)'(DEPTH));
  assign w_aw_idx = IW'({1'b0, aw_addr} % (AW+1)'(DEPTH));
  assign w_cnt_nx = r_cnt + CW'(1);
  assign w_ridx   = w_ar_hs ? w_ar_idx : r_rbase + IW'(w_cnt_nx);
  assign w_rload  = w_ar_hs || (w_r_hs && !r_rlast);
`ifdef TENSOR_MEM_BOUNDS_CHECK_EN
  logic r_rerr, r_werr, w_ar_err, w_aw_err;
  assign w_ar_err = {1'b0, ar_addr} + (AW+1)'(BEATS - 1) > (AW+1)'(DEPTH - 1);
  assign w_aw_err = {1'b0, aw_addr} + (AW+1)'(BEATS - 1) > (AW+1)'(DEPTH - 1);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rerr <= 1'b0;
      r_werr <= 1'b0;
    end else begin
      if (w_ar_hs) r_rerr <= w_ar_err;
      if (w_aw_hs) r_werr <= w_aw_err;
    end
  end
  assign w_rzero = w_ar_hs ? w_ar_err : r_rerr;
  assign w_werr  = r_werr;
  assign b_resp  = b_valid && r_werr;
`else
  assign w_rzero = 1'b0;
  assign w_werr  = 1'b0;
  assign b_resp  = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rstate <= RD_IDLE;
      r_wstate <= WR_IDLE;
    end else begin
      r_rstate <= w_rstate_nx;
      r_wstate <= w_wstate_nx;
    end
  end
  always_comb begin
    w_rstate_nx = w_ar_hs ? RD_BURST : (w_r_hs && r_rlast) ? RD_IDLE : r_rstate;
    w_wstate_nx = w_aw_hs ? WR_DATA : (w_w_hs && w_last) ? WR_RESP : w_b_hs ? WR_IDLE : r_wstate;
  end
  // Next beat is fetched on the accepting edge, so a same-cycle write is seen only by later loads.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rbase <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_rlast <= 1'b0;
    end else begin
      if (w_ar_hs) r_rbase <= w_ar_idx;
      if (w_rload) begin
        r_cnt   <= w_ar_hs ? '0 : w_cnt_nx;
        r_rdata <= w_rzero ? '0 : r_mem[w_ridx];
        r_rlast <= w_ar_hs ? (BEATS == 1) : (w_cnt_nx == CW'(BEATS - 1));
      end else if (w_r_hs) r_rlast <= 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) r_waddr <= '0;
    else if (w_aw_hs) r_waddr <= w_aw_idx;
    else if (w_w_hs) r_waddr <= r_waddr + IW'(1);
  end
  always_ff @(posedge clock) begin
    if (w_w_hs && !w_werr) r_mem[r_waddr] <= w_data;
  end
endmodule

// File: doc/tensor_mem_responder.md
TENSOR_MEM_RESPONDER -- requirements
Module: tensor_mem_responder

Interface
REQ-001: The module SHALL take parameters, one per line:
- DEPTH, 2048, memory words (power of two)
- BEATS, 4, words returned per read request
- AW, 16, address width (word address)
- DW, 32, data width

REQ-002: The module SHALL have the following ports, one per line:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- ar_addr  in  AW  read start address
- ar_valid  in  1  read request valid
- ar_ready  out  1  read request accepted
- r_data  out  DW  read beat data
- r_last  out  1  final beat of read burst
- r_valid  out  1  read beat valid
- r_ready  in  1  read beat accepted
- aw_addr  in  AW  write start address
- aw_valid  in  1  write request valid
- aw_ready  out  1  write request accepted
- w_data  in  DW  write beat data
- w_last  in  1  final write beat
- w_valid  in  1  write beat valid
- w_ready  out  1  write beat accepted
- b_resp  out  1  write response: 0 OK, 1 error
- b_valid  out  1  write response valid
- b_ready  in  1  write response accepted

REQ-003: The module SHALL accept reset as reset_n, synchronous, active-low, on clock clock.

Function
REQ-004: The module SHALL hold a DEPTH x DW register-array memory shared by independent read and write engines.
REQ-005: The module SHALL complete a handshake on any channel only on a rising edge where valid and ready are both 1.
REQ-006: The read FSM SHALL have two states: RD_IDLE (ar_ready=1, r_valid=0) and RD_BURST (ar_ready=0, r_valid=1).
REQ-007: On an ar handshake in cycle N, the module SHALL latch the address, clear the beat counter, and present r_valid=1 with r_data=mem[addr] in cycle N+1.
REQ-008: On each r handshake that is not the last beat, the module SHALL increment the beat counter and load r_data=mem[addr+count] for the next cycle.
REQ-009: While r_valid=1 and r_ready=0, the module SHALL hold r_data and r_last stable.
REQ-010: The module SHALL assert r_last only on beat BEATS-1; the r handshake of that beat SHALL return the read FSM to RD_IDLE.
REQ-011: The module SHALL compute the memory index as (address + beat) modulo DEPTH, wrapping at the top of memory.
REQ-012: The write FSM SHALL have three states:
- WR_IDLE: aw_ready=1
- WR_DATA: w_ready=1
- WR_RESP: b_valid=1
REQ-013: An aw handshake in cycle N SHALL latch the address and move to WR_DATA, so that w_ready=1 in cycle N+1.
REQ-014: Each w handshake SHALL write w_data to mem[waddr] and then increment waddr, with the same modulo-DEPTH wrap as reads.
REQ-015: The w handshake with w_last=1 SHALL move the write FSM to WR_RESP, so that b_valid=1 in the next cycle.
REQ-016: The write burst length SHALL be set solely by w_last.
REQ-017: A b handshake SHALL return the write FSM to WR_IDLE.
REQ-018: b_resp SHALL stay stable while b_valid=1.
REQ-019: When a read load and a write to the same index occur in the same cycle, the read SHALL return the pre-write value.
REQ-020: The read and write engines SHALL operate concurrently, with no ordering between them.

Reset
REQ-021: While reset_n=0, the outputs SHALL take these values:
- ar_ready=0, r_valid=0, r_last=0, r_data=0
- aw_ready=0, w_ready=0, b_valid=0, b_resp=0
REQ-022: While reset_n=0, both FSMs SHALL be forced to idle and the counters cleared.
REQ-023: The first cycle after reset release SHALL show ar_ready=1 and aw_ready=1.
REQ-024: Reset applied mid-burst SHALL abandon the burst with no response.
REQ-025: Reset SHALL NOT clear memory contents.

Configuration
REQ-026: When macro TENSOR_MEM_BOUNDS_CHECK_EN is defined, a request whose start address plus burst extent exceeds DEPTH-1 SHALL be flagged as an error.
- Reads: all beats of a flagged request return r_data=0 with normal r_last timing.
- Writes: all beats are accepted but no memory location is modified, and b_resp=1.
REQ-027: When TENSOR_MEM_BOUNDS_CHECK_EN is not defined:
- addresses SHALL wrap per REQ-011 with no error detection;
- b_resp SHALL always be 0.

Verification
REQ-028: The verification bench SHALL cover these directed scenarios:
- Write 4 beats at 0x0010 (0xA0..0xA3), r_ready=1 throughout -> b_valid one cycle after last beat, b_resp=0. Then read at 0x0010 -> r_data 0xA0,0xA1,0xA2,0xA3 with r_last on the 4th beat only.
- Read at 0x0010 with r_ready toggling 1,0,0,1 -> r_data and r_last held during stall; no beat skipped or duplicated.
- Reset pulsed mid read burst (after beat 1) -> r_valid=0 next cycle, ar_ready=1 after release, memory still returns 0xA0 at 0x0010.
- Simultaneous read of 0x0010 and write of 0xFF to 0x0010 in the same cycle -> read beat returns 0xA0; a later read returns 0xFF.
- Read at 0x07FE, BEATS=4:
  - without TENSOR_MEM_BOUNDS_CHECK_EN -> beats read indices 0x7FE,0x7FF,0x000,0x001;
  - with it -> four beats of 0, and a write at 0x07FE returns b_resp=1 and memory is unchanged.
